pcie_phase_rdctrl: RTL and testbench
====================================

PCIE_PHASE_RDCTRL -- requirements
Module: pcie_phase_rdctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: read pointer width; pointer period is 2^ADDR_WIDTH cycles.
REQ-002 SHALL have parameter EXP_PHASE, default 5: expected raddr value in the strobe-detect cycle.
REQ-003 SHALL have parameter TOL, default 1: allowed circular distance from EXP_PHASE.
REQ-004 SHALL have parameter LOCK_CNT, default 4: consecutive in-window edges required to lock.
REQ-005 SHALL have parameter ERR_LIMIT, default 2: consecutive out-of-window edges that force a slip from LOCK.
REQ-006 SHALL have port rclk  in  1  sole clock, rising edge.
REQ-007 SHALL have port npor  in  1  asynchronous active-low reset.
REQ-008 SHALL have port wstrobe  in  1  write-pointer MSB from the write clock domain, asynchronous to rclk.
REQ-009 SHALL have port clr_err  in  1  synchronous clear of err_cnt.
REQ-010 SHALL have port raddr  out  ADDR_WIDTH  read address to the phase FIFO RAM.
REQ-011 SHALL have port locked  out  1  phase lock achieved.
REQ-012 SHALL have port phase  out  ADDR_WIDTH  raddr value captured at the last detected strobe edge.
REQ-013 SHALL have port err_pulse  out  1  one-cycle error indication.
REQ-014 SHALL have port err_cnt  out  8  saturating error count.

Function
REQ-015 SHALL pass wstrobe through two synchroniser flops s1, s2 plus a history flop s3; an edge is detected when s2=1 and s3=0, two rclk edges after wstrobe rises.
REQ-016 SHALL increment raddr by 1 every cycle, wrapping 2^ADDR_WIDTH-1 -> 0, except in a slip cycle.
REQ-017 SHALL classify a detected edge as in-window when the circular distance min((raddr-EXP_PHASE) mod 2^ADDR_WIDTH, (EXP_PHASE-raddr) mod 2^ADDR_WIDTH) <= TOL (defaults: 4, 5, 6 in-window; EXP_PHASE=0 accepts 15, 0, 1).
REQ-018 SHALL load phase with the current raddr on every detected edge.
REQ-019 SHALL, on a slip, load raddr with (EXP_PHASE+1) mod 2^ADDR_WIDTH instead of incrementing it.
REQ-020 SHALL implement states IDLE, ACQ, LOCK; the state after reset is IDLE.
REQ-021 IDLE: on an in-window edge SHALL set match_cnt=1 and go to ACQ; on an out-of-window edge SHALL slip, set match_cnt=0 and go to ACQ; no error is counted in IDLE.
REQ-022 ACQ: an in-window edge SHALL increment match_cnt; when match_cnt reaches LOCK_CNT it SHALL go to LOCK with locked=1 from the next cycle; an out-of-window edge SHALL slip and clear match_cnt without an error.
REQ-023 LOCK: an in-window edge SHALL clear miss_cnt; an out-of-window edge SHALL assert err_pulse for 1 cycle, increment err_cnt and increment miss_cnt.
REQ-024 LOCK: when miss_cnt reaches ERR_LIMIT it SHALL slip on that edge, clear locked and match_cnt, clear miss_cnt and go to ACQ.
REQ-025 SHALL run a watchdog that is cleared on every detected edge and counts in ACQ and LOCK only.
REQ-026 When the watchdog reaches 2*2^ADDR_WIDTH cycles (32 by default) without an edge, it SHALL go to IDLE, clear locked, assert err_pulse for 1 cycle and increment err_cnt.
REQ-027 err_cnt SHALL saturate at 255.
REQ-028 clr_err SHALL clear err_cnt; if an increment coincides with clr_err, the result SHALL be 1.
REQ-029 err_pulse SHALL never be high for 2 consecutive cycles from a single event; an edge and a watchdog timeout cannot coincide, because an edge clears the watchdog.

Reset
REQ-030 npor low SHALL immediately force raddr=0, locked=0, phase=0, err_pulse=0, err_cnt=0, s1=s2=s3=0, all counters 0 and state=IDLE.
REQ-031 Reset deassertion SHALL be synchronised internally by a two-flop synchroniser; operation starts on the second rclk edge after npor rises.
REQ-032 npor assertion in any state, including mid-slip, SHALL take effect without waiting for an rclk edge.

Verification
REQ-033 Defaults; strobe with period 16 (8 high / 8 low) aligned so detection occurs at raddr=5 -> phase=5; locked=1 in the cycle after the 4th edge; err_cnt=0.
REQ-034 First detection at raddr=12 -> raddr=6 in the next cycle, no err_pulse; locked=1 after 4 further edges at raddr=5.
REQ-035 Locked; one edge delayed 3 cycles (phase=8) -> single err_pulse, err_cnt=1, locked stays 1; next edge at 5 clears miss_cnt.
REQ-036 Locked; two consecutive edges at phase=9 -> err_cnt=2, locked=0 and raddr=6 in the cycle after the second edge, state=ACQ.
REQ-037 Locked; wstrobe held low -> on the 32nd edge-free cycle err_pulse=1, err_cnt+1, locked=0, state=IDLE; clr_err in the same cycle -> err_cnt=1.
REQ-038 npor pulsed low while locked with err_cnt=3 -> all outputs 0 immediately; relock requires LOCK_CNT edges.

Source files
------------

// File: rtl/pcie_phase_rdctrl.sv
// Read-side phase controller for the PCIe phase FIFO: free-running read pointer
// that locks to a synchronised write-pointer MSB strobe and slips to re-centre.
//
// state | meaning
// IDLE  | no reference yet; watchdog parked; first edge decides slip or count
// ACQ   | counting consecutive in-window edges toward lock
// LOCK  | phase locked; out-of-window edges counted as errors, slip at limit
module pcie_phase_rdctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int EXP_PHASE  = 5,
    parameter int TOL        = 1,
    parameter int LOCK_CNT   = 4,
    parameter int ERR_LIMIT  = 2
) (
    input  logic                  rclk,
    input  logic                  npor,
    input  logic                  wstrobe,
    input  logic                  clr_err,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  locked,
    output logic [ADDR_WIDTH-1:0] phase,
    output logic                  err_pulse,
    output logic [7:0]            err_cnt
);

    localparam int MW   = $clog2(LOCK_CNT + 1);
    localparam int EW   = $clog2(ERR_LIMIT + 1);
    localparam int WD_W = ADDR_WIDTH + 2;

    localparam logic [ADDR_WIDTH-1:0] EXP_A   = ADDR_WIDTH'(EXP_PHASE);
    localparam logic [ADDR_WIDTH-1:0] SLIP_A  = ADDR_WIDTH'(EXP_PHASE + 1);
    localparam logic [ADDR_WIDTH-1:0] TOL_A   = ADDR_WIDTH'(TOL);
    localparam logic [MW-1:0]         LOCK_A  = MW'(LOCK_CNT);
    localparam logic [EW-1:0]         LIMIT_A = EW'(ERR_LIMIT);
    // Loaded on each edge; reaching zero then firing gives the timeout in the
    // 2*2^ADDR_WIDTH-th edge-free cycle.
    localparam logic [WD_W-1:0]       WD_LOAD = WD_W'((2 ** (ADDR_WIDTH + 1)) - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t          state;
    logic [1:0]      rst_sync;
    logic            run;
    logic            s1, s2, s3;
    logic [MW-1:0]   match_cnt;
    logic [EW-1:0]   miss_cnt;
    logic [WD_W-1:0] wd_cnt;

    logic                  edge_det;
    logic                  in_win;
    logic [ADDR_WIDTH-1:0] diff_fwd;
    logic [ADDR_WIDTH-1:0] diff_bwd;
    logic [MW-1:0]         match_nxt;
    logic [EW-1:0]         miss_nxt;
    logic                  wd_fire;
    logic                  miss_edge;
    logic                  err_inc;

    // Reset asserts asynchronously, releases two rclk edges after npor rises.
    always_ff @(posedge rclk or negedge npor) begin
        if (!npor) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run       = rst_sync[1];
    assign edge_det  = s2 & ~s3;
    assign diff_fwd  = raddr - EXP_A;
    assign diff_bwd  = EXP_A - raddr;
    assign in_win    = (diff_fwd <= TOL_A) || (diff_bwd <= TOL_A);
    assign match_nxt = match_cnt + MW'(1);
    assign miss_nxt  = miss_cnt + EW'(1);
    assign wd_fire   = (state != IDLE) && !edge_det && (wd_cnt == '0);
    assign miss_edge = (state == LOCK) && edge_det && !in_win;
    assign err_inc   = wd_fire || miss_edge;

    always_ff @(posedge rclk or negedge npor) begin
        if (!npor) begin
            state     <= IDLE;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            raddr     <= '0;
            phase     <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            wd_cnt    <= '0;
        end else if (run) begin
            s1        <= wstrobe;
            s2        <= s1;
            s3        <= s2;
            err_pulse <= 1'b0;
            raddr     <= raddr + ADDR_WIDTH'(1);

            if (edge_det) begin
                phase <= raddr;
            end

            if (edge_det || state == IDLE) begin
                wd_cnt <= WD_LOAD;
            end else if (wd_cnt != '0) begin
                wd_cnt <= wd_cnt - WD_W'(1);
            end

            case (state)
                IDLE: begin
                    if (edge_det) begin
                        state <= ACQ;
                        if (in_win) begin
                            match_cnt <= MW'(1);
                        end else begin
                            match_cnt <= '0;
                            raddr     <= SLIP_A;
                        end
                    end
                end
                ACQ: begin
                    if (edge_det) begin
                        if (in_win) begin
                            match_cnt <= match_nxt;
                            if (match_nxt == LOCK_A) begin
                                state    <= LOCK;
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else begin
                            match_cnt <= '0;
                            raddr     <= SLIP_A;
                        end
                    end else if (wd_fire) begin
                        state     <= IDLE;
                        locked    <= 1'b0;
                        err_pulse <= 1'b1;
                        match_cnt <= '0;
                    end
                end
                LOCK: begin
                    if (edge_det) begin
                        if (in_win) begin
                            miss_cnt <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            if (miss_nxt == LIMIT_A) begin
                                state     <= ACQ;
                                locked    <= 1'b0;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                                raddr     <= SLIP_A;
                            end else begin
                                miss_cnt <= miss_nxt;
                            end
                        end
                    end else if (wd_fire) begin
                        state     <= IDLE;
                        locked    <= 1'b0;
                        err_pulse <= 1'b1;
                        match_cnt <= '0;
                        miss_cnt  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Clear wins over the old value but still counts a coincident error.
    always_ff @(posedge rclk or negedge npor) begin
        if (!npor) begin
            err_cnt <= 8'd0;
        end else if (run) begin
            if (clr_err) begin
                err_cnt <= err_inc ? 8'd1 : 8'd0;
            end else if (err_inc && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pcie_phase_rdctrl.sv
// Directed bench for pcie_phase_rdctrl at default parameters: lock, single miss,
// slip after two misses, watchdog timeout with coincident clear, async reset.
module tb_pcie_phase_rdctrl;

    logic       rclk;
    logic       npor;
    logic       wstrobe;
    logic       clr_err;
    logic [3:0] raddr;
    logic       locked;
    logic [3:0] phase;
    logic       err_pulse;
    logic [7:0] err_cnt;

    int total = 0;
    int bad   = 0;

    pcie_phase_rdctrl dut (
        .rclk      (rclk),
        .npor      (npor),
        .wstrobe   (wstrobe),
        .clr_err   (clr_err),
        .raddr     (raddr),
        .locked    (locked),
        .phase     (phase),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge rclk);
    endtask

    // Entered with raddr=3 at a negedge; four strobes detected at raddr=5.
    // Returns 13 cycles after the last detect took effect, raddr=3, locked.
    task automatic four_edges(input string tag);
        for (int i = 0; i < 4; i++) begin
            wstrobe = 1'b1;
            cyc(2);
            chk({tag, "_locked_det"}, 32'(locked), 32'd0);
            cyc(1);
            chk({tag, "_phase"}, 32'(phase), 32'd5);
            chk({tag, "_locked"}, 32'(locked), (i == 3) ? 32'd1 : 32'd0);
            cyc(5);
            wstrobe = 1'b0;
            cyc(8);
        end
    endtask

    initial begin
        npor    = 1'b1;
        wstrobe = 1'b0;
        clr_err = 1'b0;
        #1 npor = 1'b0;
        #1;
        chk("rst_raddr", 32'(raddr), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_err_pulse", 32'(err_pulse), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);

        cyc(2);
        npor = 1'b1;
        cyc(2);
        chk("sync_raddr_hold", 32'(raddr), 32'd0);
        cyc(3);
        chk("run_raddr", 32'(raddr), 32'd3);

        four_edges("acq1");
        chk("acq1_err_cnt", 32'(err_cnt), 32'd0);

        // One strobe late by 3 cycles: single error, lock held
        cyc(3);
        wstrobe = 1'b1;
        cyc(3);
        chk("late_phase", 32'(phase), 32'd8);
        chk("late_err_pulse", 32'(err_pulse), 32'd1);
        chk("late_err_cnt", 32'(err_cnt), 32'd1);
        chk("late_locked", 32'(locked), 32'd1);
        cyc(1);
        chk("late_pulse_1cyc", 32'(err_pulse), 32'd0);
        cyc(4);
        wstrobe = 1'b0;
        cyc(5);

        wstrobe = 1'b1;
        cyc(3);
        chk("back_phase", 32'(phase), 32'd5);
        chk("back_err_pulse", 32'(err_pulse), 32'd0);
        chk("back_locked", 32'(locked), 32'd1);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);
        cyc(4);
        wstrobe = 1'b0;
        cyc(12);

        // Two consecutive misses at 9: first holds lock, second slips
        wstrobe = 1'b1;
        cyc(3);
        chk("miss1_phase", 32'(phase), 32'd9);
        chk("miss1_err_pulse", 32'(err_pulse), 32'd1);
        chk("miss1_err_cnt", 32'(err_cnt), 32'd1);
        chk("miss1_locked", 32'(locked), 32'd1);
        cyc(5);
        wstrobe = 1'b0;
        cyc(8);
        wstrobe = 1'b1;
        cyc(3);
        chk("miss2_phase", 32'(phase), 32'd9);
        chk("miss2_err_cnt", 32'(err_cnt), 32'd2);
        chk("miss2_locked", 32'(locked), 32'd0);
        chk("miss2_slip_raddr", 32'(raddr), 32'd6);
        chk("miss2_err_pulse", 32'(err_pulse), 32'd1);
        cyc(5);
        wstrobe = 1'b0;
        cyc(8);

        four_edges("acq2");

        // Strobe stops: timeout in the 32nd edge-free cycle, clear coincides
        cyc(17);
        chk("wd_pre_pulse", 32'(err_pulse), 32'd0);
        chk("wd_pre_locked", 32'(locked), 32'd1);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        chk("wd_err_pulse", 32'(err_pulse), 32'd1);
        chk("wd_locked", 32'(locked), 32'd0);
        chk("wd_err_cnt_clr", 32'(err_cnt), 32'd1);
        cyc(1);
        chk("wd_pulse_1cyc", 32'(err_pulse), 32'd0);
        cyc(40);
        chk("idle_no_wd_err", 32'(err_cnt), 32'd1);
        chk("idle_raddr", 32'(raddr), 32'd14);

        // From IDLE, first edge far out of window at 12: slip, no error
        cyc(12);
        wstrobe = 1'b1;
        cyc(3);
        chk("idle_slip_raddr", 32'(raddr), 32'd6);
        chk("idle_slip_phase", 32'(phase), 32'd12);
        chk("idle_slip_pulse", 32'(err_pulse), 32'd0);
        chk("idle_slip_err_cnt", 32'(err_cnt), 32'd1);
        cyc(5);
        wstrobe = 1'b0;
        cyc(8);

        four_edges("acq3");

        // Async reset while locked, between clock edges
        #1 npor = 1'b0;
        #1;
        chk("arst_raddr", 32'(raddr), 32'd0);
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_phase", 32'(phase), 32'd0);
        chk("arst_err_cnt", 32'(err_cnt), 32'd0);
        chk("arst_err_pulse", 32'(err_pulse), 32'd0);
        cyc(1);
        npor = 1'b1;
        cyc(2);
        chk("arst_sync_hold", 32'(raddr), 32'd0);
        cyc(3);
        chk("arst_run_raddr", 32'(raddr), 32'd3);
        four_edges("acq4");
        chk("acq4_err_cnt", 32'(err_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "bench time limit reached");
    end

endmodule
